// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter in front of an APB3 master: shares one APB bus among NUM_REQ
// requesters, runs SETUP/ACCESS with an optional pready timeout, returns done/err/rdata.
module apb_master_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                  pclk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [NUM_REQ*DW-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    done,
  output logic                  err,
  output logic [DW-1:0]         rdata,
  output logic [AW-1:0]         paddr,
  output logic                  pwrite,
  output logic                  psel,
  output logic                  penable,
  output logic [DW-1:0]         pwdata,
  input  logic [DW-1:0]         prdata,
  input  logic                  pready
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]       grant_q, grant_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [AW-1:0]       paddr_q, paddr_d;
  logic                pwrite_q, pwrite_d;
  logic [DW-1:0]       pwdata_q, pwdata_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic                err_q, err_d;
  logic [DW-1:0]       rdata_q, rdata_d;

  logic [IW-1:0]       pick_s;
  logic                pick_vld_s;
  logic [IW:0]         sum_s;
  logic [IW:0]         wrap_s;
  logic                timeout_s;

  // Round-robin search: first set request strictly after rr_ptr, wrapping around.
  always_comb begin
    pick_s     = rr_ptr_q;
    pick_vld_s = 1'b0;
    sum_s      = '0;
    wrap_s     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sum_s      = {1'b0, rr_ptr_q} + (IW+1)'(k);
      wrap_s     = (sum_s >= (IW+1)'(NUM_REQ)) ? (sum_s - (IW+1)'(NUM_REQ)) : sum_s;
      pick_s     = (req[wrap_s[IW-1:0]] && !pick_vld_s) ? wrap_s[IW-1:0] : pick_s;
      pick_vld_s = pick_vld_s | req[wrap_s[IW-1:0]];
    end
  end

  assign timeout_s = (TIMEOUT != 0) && !pready && (cnt_q == CW'(TIMEOUT - 1));

  // State register and all registered outputs.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_ptr_q  <= IW'(NUM_REQ - 1);
      grant_q   <= '0;
      cnt_q     <= '0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      done_q    <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      cnt_q     <= cnt_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = pick_vld_s ? SETUP : IDLE;
      SETUP:   state_d = ACCESS;
      ACCESS:  state_d = (pready || timeout_s) ? DONE : ACCESS;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values; APB strobes follow the state being entered.
  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    done_d    = '0;
    err_d     = 1'b0;
    rdata_d   = '0;
    psel_d    = (state_d == SETUP) || (state_d == ACCESS);
    penable_d = (state_d == ACCESS);
    case (state_q)
      IDLE: begin
        if (pick_vld_s) begin
          rr_ptr_d = pick_s;
          grant_d  = pick_s;
          paddr_d  = req_addr[pick_s*AW +: AW];
          pwrite_d = req_write[pick_s];
          pwdata_d = req_wdata[pick_s*DW +: DW];
        end else begin
          rr_ptr_d = rr_ptr_q;
        end
      end
      SETUP: cnt_d = '0;
      ACCESS: begin
        if (pready) begin
          done_d  = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q;
          rdata_d = pwrite_q ? '0 : prdata;
        end else if (timeout_s) begin
          done_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q;
          err_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    cnt_d = cnt_q;
      default: cnt_d = '0;
    endcase
  end

  assign done    = done_q;
  assign err     = err_q;
  assign rdata   = rdata_q;
  assign paddr   = paddr_q;
  assign pwrite  = pwrite_q;
  assign pwdata  = pwdata_q;
  assign psel    = psel_q;
  assign penable = penable_q;

endmodule
